// File: rtl/sum_collector.sv
// sum_collector: packs NIBBLES consecutive 4-bit adder results (and each
// stage carry-out) into one output word, with a one-deep output buffer,
// a synchronous flush and a sticky overrun flag for dropped words.
module sum_collector #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [3:0]             sum,
    input  logic [3:0]             c_out,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic [NIBBLES-1:0]     out_carry,
    output logic                   overrun,
    output logic                   busy
);

    localparam int CW = $clog2(NIBBLES);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*NIBBLES-1:0]   asm_q, asm_d;
    logic [NIBBLES-1:0]     asm_carry_q, asm_carry_d;
    logic                   out_valid_q;
    logic [4*NIBBLES-1:0]   out_data_q;
    logic [NIBBLES-1:0]     out_carry_q;
    logic                   overrun_q;
    logic                   complete;
    logic                   load;

    // Next-state for the assembly path: flush wins, otherwise insert the nibble at slot cnt.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        asm_carry_d = asm_carry_q;
        complete    = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            asm_d       = '0;
            asm_carry_d = '0;
        end else if (in_valid) begin
            // sum/c_out are only sampled here, so X on them while idle never propagates.
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt_q == CW'(i)) begin
                    asm_d[4*i +: 4] = sum;
                    asm_carry_d[i]  = c_out[3];
                end
            end
            if (cnt_q == CW'(NIBBLES - 1)) begin
                complete = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                state_d  = COLLECT;
            end
        end
    end

    // A completed word enters the buffer if it is empty or being drained this same cycle.
    assign load = complete && (!out_valid_q || out_ready);

    // State, assembly and output-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the assembly registers are reset too, so a word cut short by reset never leaks out.
            state_q     <= IDLE;
            cnt_q       <= '0;
            asm_q       <= '0;
            asm_carry_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            asm_carry_q <= asm_carry_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= asm_d;
                out_carry_q <= asm_carry_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (complete && out_valid_q && !out_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector (NIBBLES=4): a vector table for the
// basic pack / flush / drain behaviour plus hand-written multi-cycle sequences.
module tb_sum_collector;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [3:0]     sum;
    logic [3:0]     c_out;
    logic           flush;
    logic           out_ready;
    logic           out_valid;
    logic [4*N-1:0] out_data;
    logic [N-1:0]   out_carry;
    logic           overrun;
    logic           busy;

    int n_cmp  = 0;
    int n_fail = 0;

    sum_collector #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_carry (out_carry),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  s;
        logic        c3;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_data;
        logic [3:0]  e_carry;
        logic        e_ovr;
        logic        e_busy;
    } vec_t;

    vec_t vec [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given inputs applied; outputs are sampled 1 ns after the edge.
    task automatic step(input logic iv, input logic [3:0] s, input logic c3,
                        input logic fl, input logic rdy);
        in_valid  = iv;
        sum       = iv ? s : 4'bxxxx;
        c_out     = iv ? {c3, 3'b101} : 4'bxxxx;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] d,
                             input logic [3:0] c, input logic o, input logic b);
        check({name, " valid"}, 32'(out_valid), 32'(v));
        check({name, " data"},  32'(out_data),  32'(d));
        check({name, " carry"}, 32'(out_carry), 32'(c));
        check({name, " ovr"},   32'(overrun),   32'(o));
        check({name, " busy"},  32'(busy),      32'(b));
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            iv   s     c3    fl    rdy   v     data      carry  ov    busy
        vec[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        vec[1]  = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4321, 4'hA, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 4'hD, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b1};
        vec[10] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hA, 1'b0, 1'b1};
        vec[11] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 4'h0, 1'b0, 1'b0};
        vec[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 4'h0, 1'b0, 1'b0};
        vec[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'h0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; sum = 4'hx; c_out = 4'hx;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check_out("reset", 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pack, drain, flush-with-nibble, backpressure hold and release.
        for (int i = 0; i < 14; i++) begin
            step(vec[i].iv, vec[i].s, vec[i].c3, vec[i].fl, vec[i].rdy);
            check_out($sformatf("vec%0d", i), vec[i].e_valid, vec[i].e_data,
                      vec[i].e_carry, vec[i].e_ovr, vec[i].e_busy);
        end

        // Gapped input: two idle cycles between nibbles, busy held throughout.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'(k + 1), 1'(k % 2), 1'b0, 1'b1);
            if (k < 3) begin
                check($sformatf("gap n%0d busy", k), 32'(busy), 32'd1);
                idle(1'b1);
                idle(1'b1);
                check($sformatf("gap n%0d busy held", k), 32'(busy), 32'd1);
                check($sformatf("gap n%0d no out", k), 32'(out_valid), 32'd0);
            end
        end
        check_out("gap done", 1'b1, 16'h4321, 4'hA, 1'b0, 1'b0);
        idle(1'b1);

        // Backpressure: second word is dropped, overrun sticks, 0x2222 never appears.
        for (int k = 0; k < 4; k++) step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        check_out("bp w1", 1'b1, 16'h1111, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
        check_out("bp w2 drop", 1'b1, 16'h1111, 4'h0, 1'b1, 1'b0);
        idle(1'b1);
        check_out("bp drain", 1'b0, 16'h1111, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check($sformatf("bp after%0d valid", k), 32'(out_valid), 32'd0);
            check($sformatf("bp after%0d data", k), 32'(out_data), 32'h1111);
        end
        check("bp ovr sticky", 32'(overrun), 32'd1);

        // Reset clears the sticky overrun.
        pulse_reset();
        check("ovr cleared", 32'(overrun), 32'd0);

        // Simultaneous drain and load.
        for (int k = 0; k < 4; k++) step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        check_out("dl first", 1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        check("dl hold", 32'(out_data), 32'hAAAA);
        step(1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        check_out("dl swap", 1'b1, 16'h5555, 4'hF, 1'b0, 1'b0);
        idle(1'b1);
        check("dl drained", 32'(out_valid), 32'd0);

        // Async reset mid-collection with a word pending in the buffer.
        for (int k = 0; k < 4; k++) step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 4'(k + 1), 1'b1, 1'b0, 1'b0);
        check_out("pre rst", 1'b1, 16'h9999, 4'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("async rst", 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, 4'(k + 5), 1'b0, 1'b0, 1'b1);
        check_out("post rst", 1'b1, 16'h8765, 4'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
